// File: rtl/mac_bank_multichannel.sv
// rtl/mac_bank_multichannel.sv - time-multiplexed multichannel signed MAC with rounded, saturated output
// Three registered stages: product, per-channel accumulate, round/clip.
module mac_bank_multichannel #(
    parameter int NCH         = 4,
    parameter int SAMPLE_SIZE = 16,
    parameter int COEFF_SIZE  = 16,
    parameter int GUARD       = 4,
    parameter int PRE_SHIFT   = 3,
    parameter int OUT_SHIFT   = 12,
    parameter int OUT_SIZE    = 16,
    localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [CHW-1:0]         ch_in,
    input  logic [SAMPLE_SIZE-1:0] s_in,
    input  logic [COEFF_SIZE-1:0]  c_in,
    output logic                   out_valid,
    output logic [CHW-1:0]         out_ch,
    output logic [OUT_SIZE-1:0]    dout,
    output logic                   out_sat,
    output logic                   ovf
);
    localparam int PW    = SAMPLE_SIZE + COEFF_SIZE;
    localparam int ACC_W = PW + GUARD;
    localparam logic [CHW:0]              NCH_LIM = (CHW+1)'(NCH);
    localparam logic signed [ACC_W:0]     HALF    = (ACC_W+1)'(1) <<< (OUT_SHIFT-1);
    localparam logic signed [ACC_W:0]     OMAX    = (ACC_W+1)'((64'sd1 <<< (OUT_SIZE-1)) - 1);
    localparam logic signed [ACC_W:0]     OMIN    = ~OMAX;

    logic signed [PW-1:0]    mult, mult_sh;
    logic signed [ACC_W-1:0] prod_d;
    logic                    tap_ok;

    logic                    v1_q, first1_q, last1_q;
    logic [CHW-1:0]          ch1_q;
    logic signed [ACC_W-1:0] prod1_q;

    logic signed [ACC_W-1:0] acc_q [NCH];
    logic signed [ACC_W-1:0] base, sum_d;
    logic                    wrap;

    logic                    emit2_q;
    logic [CHW-1:0]          ch2_q;
    logic signed [ACC_W-1:0] sum2_q;

    logic signed [ACC_W:0]   rnd, r;
    logic                    hi, lo;
    logic [OUT_SIZE-1:0]     dout_d;

    logic                    out_valid_q, out_sat_q, ovf_q;
    logic [CHW-1:0]          out_ch_q;
    logic [OUT_SIZE-1:0]     dout_q;

    assign mult    = $signed(s_in) * $signed(c_in);
    assign mult_sh = mult >>> PRE_SHIFT;
    assign prod_d  = ACC_W'(mult_sh);
    // Taps addressed to a nonexistent channel never enter the pipeline.
    assign tap_ok  = in_valid && ({1'b0, ch_in} < NCH_LIM);

    // Reading acc_q here sees the previous cycle's write, so same-channel taps need no bubble.
    assign base  = first1_q ? '0 : acc_q[ch1_q];
    assign sum_d = base + prod1_q;
    assign wrap  = (base[ACC_W-1] == prod1_q[ACC_W-1]) && (sum_d[ACC_W-1] != base[ACC_W-1]);

    // One extra bit keeps the rounding offset from wrapping a near-full accumulator.
    assign rnd    = {sum2_q[ACC_W-1], sum2_q} + HALF;
    assign r      = rnd >>> OUT_SHIFT;
    assign hi     = r > OMAX;
    assign lo     = r < OMIN;
    assign dout_d = hi ? OMAX[OUT_SIZE-1:0] : (lo ? OMIN[OUT_SIZE-1:0] : r[OUT_SIZE-1:0]);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            v1_q        <= 1'b0;
            first1_q    <= 1'b0;
            last1_q     <= 1'b0;
            ch1_q       <= '0;
            prod1_q     <= '0;
            emit2_q     <= 1'b0;
            ch2_q       <= '0;
            sum2_q      <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            dout_q      <= '0;
            out_sat_q   <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
        end else if (clear) begin
            v1_q        <= 1'b0;
            emit2_q     <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
        end else begin
            v1_q     <= tap_ok;
            first1_q <= in_first;
            last1_q  <= in_last;
            ch1_q    <= ch_in;
            prod1_q  <= prod_d;

            emit2_q <= v1_q && last1_q;
            ch2_q   <= ch1_q;
            sum2_q  <= sum_d;
            if (v1_q) begin
                acc_q[ch1_q] <= sum_d;
                if (wrap) ovf_q <= 1'b1;
            end

            out_valid_q <= emit2_q;
            if (emit2_q) begin
                dout_q    <= dout_d;
                out_sat_q <= hi || lo;
                out_ch_q  <= ch2_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign dout      = dout_q;
    assign out_sat   = out_sat_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_mac_bank_multichannel.sv
// tb/tb_mac_bank_multichannel.sv - randomized bench for mac_bank_multichannel against an arithmetic reference model
// A second instance (GUARD=0, NCH=3) exposes accumulator wrap and out-of-range channel drops.
module tb_mac_bank_multichannel;
    logic        clk = 1'b0, nrst = 1'b0, clear = 1'b0;
    logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
    logic [1:0]  ch_in = '0;
    logic [15:0] s_in = '0, c_in = '0;
    logic        out_valid, out_sat, ovf;
    logic [1:0]  out_ch;
    logic [15:0] dout;
    logic        g_out_valid, g_out_sat, g_ovf;
    logic [1:0]  g_out_ch;
    logic [15:0] g_dout;

    mac_bank_multichannel dut (
        .clk(clk), .nrst(nrst), .clear(clear), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .ch_in(ch_in), .s_in(s_in), .c_in(c_in), .out_valid(out_valid),
        .out_ch(out_ch), .dout(dout), .out_sat(out_sat), .ovf(ovf)
    );

    mac_bank_multichannel #(.NCH(3), .GUARD(0)) dut_g0 (
        .clk(clk), .nrst(nrst), .clear(clear), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .ch_in(ch_in), .s_in(s_in), .c_in(c_in), .out_valid(g_out_valid),
        .out_ch(g_out_ch), .dout(g_dout), .out_sat(g_out_sat), .ovf(g_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] d;
        logic        sat;
    } res_t;

    res_t   exp_q[$];
    longint acc_m [2][4];
    bit     ovf_m [2];
    int     nch_m [2] = '{4, 3};
    int     accw_m[2] = '{36, 32};
    int     n_cmp = 0, n_bad = 0;

    function automatic longint wrapw(longint x, int w);
        longint m;
        m = x & ((longint'(1) << w) - 1);
        if (m[w-1]) m = m - (longint'(1) << w);
        return m;
    endfunction

    task automatic model_tap(bit f, bit l, int ch, logic [15:0] s, logic [15:0] c);
        longint p, raw, w, r;
        res_t   e;
        for (int k = 0; k < 2; k++) begin
            if (ch < nch_m[k]) begin
                p   = (longint'($signed(s)) * longint'($signed(c))) >>> 3;
                raw = (f ? 64'sd0 : acc_m[k][ch]) + p;
                w   = wrapw(raw, accw_m[k]);
                if (w != raw) ovf_m[k] = 1'b1;
                acc_m[k][ch] = w;
                if (k == 0 && l) begin
                    r     = (w + 2048) >>> 12;
                    e.ch  = ch[1:0];
                    e.sat = (r > 32767) || (r < -32768);
                    e.d   = (r > 32767) ? 16'h7fff : ((r < -32768) ? 16'h8000 : r[15:0]);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ovf_m[k] = 1'b0;
            for (int i = 0; i < 4; i++) acc_m[k][i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic drive(bit v, bit f, bit l, int ch, logic [15:0] s, logic [15:0] c);
        in_valid = v; in_first = f; in_last = l; ch_in = ch[1:0]; s_in = s; c_in = c;
        @(posedge clk);
        if (v && !clear) model_tap(f, l, ch, s, c);
        #1;
    endtask

    task automatic idle(int n);
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        model_reset();
        #1 clear = 1'b0;
    endtask

    task automatic check_drained(string tag);
        idle(6);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_missing_outputs got %0d pending required 0", tag, exp_q.size());
            exp_q.delete();
        end
        n_cmp++;
        if (ovf !== ovf_m[0] || g_ovf !== ovf_m[1]) begin
            n_bad++;
            $display("FAIL %s_ovf got %b/%b required %b/%b", tag, ovf, g_ovf, ovf_m[0], ovf_m[1]);
        end
    endtask

    task automatic check_last(string tag, logic [1:0] ch, logic [15:0] d, logic sat);
        n_cmp++;
        if (out_ch !== ch || dout !== d || out_sat !== sat) begin
            n_bad++;
            $display("FAIL %s got ch=%0d dout=%h sat=%b required ch=%0d dout=%h sat=%b",
                     tag, out_ch, dout, out_sat, ch, d, sat);
        end
    endtask

    always @(negedge clk) begin : monitor
        res_t e;
        if (nrst && out_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL out_unexpected got ch=%0d dout=%h required no output", out_ch, dout);
            end else begin
                e = exp_q.pop_front();
                if (out_ch !== e.ch || dout !== e.d || out_sat !== e.sat) begin
                    n_bad++;
                    $display("FAIL out_result got ch=%0d dout=%h sat=%b required ch=%0d dout=%h sat=%b",
                             out_ch, dout, out_sat, e.ch, e.d, e.sat);
                end
            end
        end
    end

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_ch !== 2'd0 || dout !== 16'h0 || out_sat !== 1'b0 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got v=%b ch=%0d dout=%h sat=%b ovf=%b required all 0",
                     out_valid, out_ch, dout, out_sat, ovf);
        end
        @(negedge clk) nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic seen[3];
        drive(1, 1, 1, 0, 16'h4000, 16'h4000);
        idle(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen[i] = out_valid;
        end
        n_cmp++;
        if (seen[0] !== 1'b0 || seen[1] !== 1'b0 || seen[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL single_latency got %b%b%b required 001", seen[0], seen[1], seen[2]);
        end
        check_last("single_value", 2'd0, 16'h2000, 1'b0);
        check_drained("single");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 8; i++) drive(1, i == 0, i == 7, 1, 16'h7fff, 16'h7fff);
        check_drained("sat_pos");
        check_last("sat_pos_value", 2'd1, 16'h7fff, 1'b1);
        for (int i = 0; i < 4; i++) drive(1, i == 0, i == 3, 2, 16'h8000, 16'h7fff);
        check_drained("sat_neg");
        check_last("sat_neg_value", 2'd2, 16'h8000, 1'b1);
    endtask

    task automatic test_rounding();
        drive(1, 1, 1, 0, 16'h0001, 16'h4000);
        check_drained("round_up");
        check_last("round_up_value", 2'd0, 16'h0001, 1'b0);
        drive(1, 1, 1, 0, 16'h0001, 16'h3ff8);
        check_drained("round_down");
        check_last("round_down_value", 2'd0, 16'h0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(1, i == 0, i == 3, 0, 16'h4000, 16'h1000);
            drive(1, i == 0, i == 3, 1, 16'h4000, 16'h2000);
        end
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
            n_bad++;
            $display("FAIL interleave_first got v=%b ch=%0d required v=1 ch=0", out_valid, out_ch);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1) begin
            n_bad++;
            $display("FAIL interleave_second got v=%b ch=%0d required v=1 ch=1", out_valid, out_ch);
        end
        check_drained("interleave");
        check_last("interleave_value", 2'd1, 16'h4000, 1'b0);
    endtask

    task automatic test_clear_midframe();
        drive(1, 1, 0, 3, 16'h1234, 16'h4321);
        drive(1, 0, 1, 3, 16'h1234, 16'h4321);
        clear = 1'b1;
        drive(1, 0, 1, 3, 16'h7fff, 16'h7fff);
        model_reset();
        clear = 1'b0;
        check_drained("clear_flush");
        drive(1, 1, 0, 3, 16'h4000, 16'h4000);
        drive(1, 0, 1, 3, 16'h4000, 16'h4000);
        check_drained("clear_resume");
        check_last("clear_resume_value", 2'd3, 16'h4000, 1'b0);

        drive(1, 1, 0, 3, 16'h1111, 16'h2222);
        drive(1, 0, 1, 3, 16'h1111, 16'h2222);
        in_valid = 1'b0;
        nrst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || dout !== 16'h0 || out_sat !== 1'b0 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset got v=%b dout=%h sat=%b ovf=%b required all 0",
                     out_valid, dout, out_sat, ovf);
        end
        @(negedge clk) nrst = 1'b1;
        check_drained("reset_flush");
        drive(1, 1, 0, 3, 16'h4000, 16'h4000);
        drive(1, 0, 1, 3, 16'h4000, 16'h4000);
        check_drained("reset_resume");
        check_last("reset_resume_value", 2'd3, 16'h4000, 1'b0);
    endtask

    task automatic test_ovf_guard0();
        int g_pulses;
        do_clear();
        for (int i = 0; i < 20; i++) drive(1, i == 0, 0, 0, 16'h7fff, 16'h7fff);
        drive(1, 1, 1, 3, 16'h4000, 16'h4000);
        in_valid = 1'b0;
        g_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (g_out_valid === 1'b1) g_pulses++;
        end
        n_cmp++;
        if (g_pulses != 0) begin
            n_bad++;
            $display("FAIL dropped_channel_output got %0d pulses required 0", g_pulses);
        end
        check_drained("ovf_set");
        n_cmp++;
        if (g_ovf !== 1'b1 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_wrap got g0=%b main=%b required g0=1 main=0", g_ovf, ovf);
        end
        drive(1, 1, 0, 0, 16'h0001, 16'h0001);
        check_drained("ovf_sticky");
        n_cmp++;
        if (g_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_sticky got %b required 1", g_ovf);
        end
        do_clear();
        #1;
        n_cmp++;
        if (g_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear got %b required 0", g_ovf);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3), 16'($urandom), 16'($urandom));
        end
        check_drained("random");
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog_timeout got running required finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_saturate();
        test_rounding();
        test_back_to_back();
        test_clear_midframe();
        test_ovf_guard0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
